// File: rtl/simeck_round_engine.sv
// rtl/simeck_round_engine.sv - Iterative Simeck32/64 core, one round per clock.
// Define SIMECK_DECRYPT_EN to add the round-key store and the decrypt path.
module simeck_round_engine #(
    parameter int N      = 16,
    parameter int ROUNDS = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           mode,
    input  logic [2*N-1:0] data_in,
    input  logic [4*N-1:0] key_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] data_out,
    output logic           busy
);
    if (N != 16) begin : g_bad_n
        $error("simeck_round_engine supports only N = 16");
    end

    localparam int            CW   = $clog2(ROUNDS);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);
    localparam logic [N-1:0]  C    = {{(N-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {IDLE, RUN, DONE, EXPAND, DRUN} state_t;

    state_t        state, state_next;
    logic [N-1:0]  x1, x0, t0, t1, t2, t3;
    logic [CW-1:0] cnt;
    logic [4:0]    lfsr;
    logic [2*N-1:0] dout;
    logic          last;
    logic [N-1:0]  new_t3, enc_l;

    function automatic logic [N-1:0] f(input logic [N-1:0] x);
        return (x & {x[N-6:0], x[N-1:N-5]}) ^ {x[N-2:0], x[N-1]};
    endfunction

    assign last   = (cnt == LAST);
    assign new_t3 = t0 ^ f(t1) ^ C ^ {{(N-1){1'b0}}, lfsr[0]};
    assign enc_l  = x0 ^ f(x1) ^ t0;

`ifdef SIMECK_DECRYPT_EN
    logic [N-1:0] ks [ROUNDS];
    logic [N-1:0] dec_r;
    // Inverse rounds walk the stored schedule from the last key back to k_0.
    assign dec_r = x1 ^ f(x0) ^ ks[LAST - cnt];
`else
    logic mode_unused;
    assign mode_unused = mode;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) begin
`ifdef SIMECK_DECRYPT_EN
                state_next = mode ? EXPAND : RUN;
`else
                state_next = RUN;
`endif
            end
            RUN:  if (last) state_next = DONE;
`ifdef SIMECK_DECRYPT_EN
            EXPAND: if (last) state_next = DRUN;
            DRUN:   if (last) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        data_out  = dout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x1   <= '0;
            x0   <= '0;
            t0   <= '0;
            t1   <= '0;
            t2   <= '0;
            t3   <= '0;
            cnt  <= '0;
            lfsr <= 5'b11111;
            dout <= '0;
`ifdef SIMECK_DECRYPT_EN
            for (int i = 0; i < ROUNDS; i++) ks[i] <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    {x1, x0}         <= data_in;
                    {t3, t2, t1, t0} <= key_in;
                    cnt              <= '0;
                    lfsr             <= 5'b11111;
                end
                RUN: begin
                    x1   <= enc_l;
                    x0   <= x1;
                    t0   <= t1;
                    t1   <= t2;
                    t2   <= t3;
                    t3   <= new_t3;
                    cnt  <= cnt + CW'(1);
                    lfsr <= {lfsr[2] ^ lfsr[0], lfsr[4:1]};
                    if (last) dout <= {enc_l, x1};
                end
`ifdef SIMECK_DECRYPT_EN
                EXPAND: begin
                    ks[cnt] <= t0;
                    t0      <= t1;
                    t1      <= t2;
                    t2      <= t3;
                    t3      <= new_t3;
                    cnt     <= cnt + CW'(1);
                    lfsr    <= {lfsr[2] ^ lfsr[0], lfsr[4:1]};
                end
                DRUN: begin
                    x1  <= x0;
                    x0  <= dec_r;
                    cnt <= cnt + CW'(1);
                    if (last) dout <= {x0, dec_r};
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_simeck_round_engine.sv
// tb/tb_simeck_round_engine.sv - Randomized self-checking bench for simeck_round_engine.
module tb_simeck_round_engine;
    localparam logic [63:0] VK = 64'h1918_1110_0908_0100;
    localparam logic [31:0] VP = 32'h6565_6877;
    localparam logic [31:0] VC = 32'h770d_2c76;
`ifdef SIMECK_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, mode, out_ready;
    logic [31:0] data_in;
    logic [63:0] key_in;
    logic        in_ready, out_valid, busy;
    logic [31:0] data_out;
    int          errors = 0;
    int          checks = 0;

    simeck_round_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .data_in(data_in), .key_in(key_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] rotl(input logic [15:0] x, input int s);
        return (x << s) | (x >> (16 - s));
    endfunction

    function automatic logic [15:0] rf(input logic [15:0] x);
        return (x & rotl(x, 5)) ^ rotl(x, 1);
    endfunction

    // Reference cipher: full key schedule first, then the 32 rounds.
    function automatic logic [31:0] ref_cipher(input logic [63:0] key, input logic [31:0] blk, input bit dec);
        logic [15:0] k [32];
        bit          z [32];
        logic [15:0] l, r, tmp;
        for (int i = 0; i < 5; i++) z[i] = 1'b1;
        for (int i = 5; i < 32; i++) z[i] = z[i-3] ^ z[i-5];
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 0; i < 28; i++) k[i+4] = k[i] ^ rf(k[i+1]) ^ 16'hFFFC ^ {15'b0, z[i]};
        l = blk[31:16];
        r = blk[15:0];
        if (!dec) begin
            for (int i = 0; i < 32; i++) begin
                tmp = l; l = r ^ rf(l) ^ k[i]; r = tmp;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                tmp = r; r = l ^ rf(r) ^ k[i]; l = tmp;
            end
        end
        return {l, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic [63:0] k, input logic [31:0] d, input bit m, output bit ok);
        int guard = 0;
        ok = 1'b0;
        while (!in_ready && guard < 200) begin tick(); guard++; end
        if (in_ready) begin
            key_in = k; data_in = d; mode = m; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin tick(); lat++; end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
        data_in = '0; key_in = '0;
        tick();
        checks++;
        if ({in_ready, out_valid, busy, data_out} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b data_out=%h, want 1 0 0 00000000",
                     in_ready, out_valid, busy, data_out);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_encrypt();
        bit ok; int lat;
        out_ready = 1'b1;
        submit(VK, VP, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL enc_accept: in_ready never rose"); end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL enc_busy: busy=%b in_ready=%b, want 1 0", busy, in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat != 32) begin errors++; $display("FAIL enc_latency: got %0d want 32", lat); end
        checks++;
        if (data_out !== VC) begin errors++; $display("FAIL enc_vector: got %h want %h", data_out, VC); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL enc_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int lat; int bad = 0;
        out_ready = 1'b0;
        submit(VK, VP, 1'b0, ok);
        wait_valid(lat);
        checks++;
        if (!ok || lat != 32 || data_out !== VC) begin
            errors++; $display("FAIL bp_result: ok=%b lat=%0d data=%h, want 1 32 %h", ok, lat, data_out, VC);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || data_out !== VC || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_ignored();
        bit ok; int lat; int bad = 0; int hold_bad = 0;
        logic [63:0] kb; logic [31:0] db;
        out_ready = 1'b1;
        submit(VK, VP, 1'b0, ok);
        repeat (4) tick();
        data_in = 32'hFFFF_FFFF; key_in = {$urandom, $urandom}; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_ready !== 1'b0) bad++;
            tick();
        end
        in_valid = 1'b0;
        wait_valid(lat);
        checks++;
        if (bad != 0 || data_out !== VC) begin
            errors++; $display("FAIL ign_result: in_ready_high=%0d data=%h, want 0 %h", bad, data_out, VC);
        end
        out_ready = 1'b0;
        kb = {$urandom, $urandom}; db = $urandom;
        key_in = kb; data_in = db; mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== VC) hold_bad++;
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL ign_done_hold: %0d bad cycles, want 0", hold_bad); end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ign_idle: in_ready=%b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        checks++;
        if (lat != 32 || data_out !== ref_cipher(kb, db, 1'b0)) begin
            errors++; $display("FAIL ign_second: lat=%0d data=%h, want 32 %h", lat, data_out, ref_cipher(kb, db, 1'b0));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; int seen = 0;
        out_ready = 1'b1;
        submit(VK, VP, 1'b0, ok);
        repeat (10) tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, data_out} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_async: in_ready=%b out_valid=%b busy=%b data_out=%h, want 1 0 0 00000000",
                     in_ready, out_valid, busy, data_out);
        end
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_no_output: out_valid high %0d cycles, want 0", seen); end
        submit(VK, VP, 1'b0, ok);
        wait_valid(lat);
        checks++;
        if (!ok || lat != 32 || data_out !== VC) begin
            errors++; $display("FAIL rst_resubmit: ok=%b lat=%0d data=%h, want 1 32 %h", ok, lat, data_out, VC);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc [2]; logic [31:0] res [2];
        int nacc = 0; int nres = 0; int cyc = 0; bit acc_now;
        logic [63:0] kb = {$urandom, $urandom};
        logic [31:0] db = $urandom;
        acc[0] = 0; acc[1] = 0; res[0] = '0; res[1] = '0;
        out_ready = 1'b1; mode = 1'b0; key_in = VK; data_in = VP; in_valid = 1'b1;
        while (nres < 2 && cyc < 200) begin
            acc_now = 1'b0;
            if (in_valid && in_ready && nacc < 2) begin acc[nacc] = cyc; nacc++; acc_now = 1'b1; end
            if (out_valid && out_ready) begin res[nres] = data_out; nres++; end
            tick();
            cyc++;
            if (acc_now) begin
                if (nacc == 1) begin key_in = kb; data_in = db; end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nres != 2 || acc[1] - acc[0] != 34) begin
            errors++; $display("FAIL b2b_spacing: results=%0d spacing=%0d, want 2 34", nres, acc[1] - acc[0]);
        end
        checks++;
        if (res[0] !== VC || res[1] !== ref_cipher(kb, db, 1'b0)) begin
            errors++; $display("FAIL b2b_data: got %h %h want %h %h", res[0], res[1], VC, ref_cipher(kb, db, 1'b0));
        end
    endtask

    task automatic test_decrypt();
        bit ok; int lat;
        logic [31:0] exp_d = DEC_EN ? VP : ref_cipher(VK, VC, 1'b0);
        int exp_l = DEC_EN ? 64 : 32;
        out_ready = 1'b1;
        submit(VK, VC, 1'b1, ok);
        wait_valid(lat);
        checks++;
        if (!ok || lat != exp_l || data_out !== exp_d) begin
            errors++; $display("FAIL dec_vector: ok=%b lat=%0d data=%h, want 1 %0d %h", ok, lat, data_out, exp_l, exp_d);
        end
        tick();
    endtask

    task automatic test_random();
        bit ok; int lat; bit m; bit dec;
        logic [63:0] k; logic [31:0] d; logic [31:0] exp_d;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            k = {$urandom, $urandom}; d = $urandom; m = 1'($urandom_range(0, 1));
            dec = m && DEC_EN;
            exp_d = ref_cipher(k, d, dec);
            submit(k, d, m, ok);
            wait_valid(lat);
            checks++;
            if (!ok || lat != (dec ? 64 : 32) || data_out !== exp_d) begin
                errors++;
                $display("FAIL rand_%0d: mode=%b ok=%b lat=%0d data=%h, want %0d %h",
                         i, m, ok, lat, data_out, dec ? 64 : 32, exp_d);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_backpressure();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        test_decrypt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
